gate_model_bist: RTL
====================

Name: gate_model_bist

Overview:
Built-in self-test controller for the combinational gate netlists of the simulator's gate library (14 inputs, 10 outputs).
- Generates pseudo-random stimulus with an LFSR and drives it onto the netlist inputs.
- Compacts the netlist responses into a MISR signature and compares the final signature with a golden value.
- Sits between the lab front-end (start/done/pass) and one gate model instance.

Parameters:
IN_W, 14, stimulus width (netlist inputs N1..N14; tpg_out[0] drives N1).
OUT_W, 10, response width (netlist outputs; must be <= SIG_W).
SIG_W, 16, MISR signature width.
PATTERNS, 256, number of patterns per run (1..65535).
LFSR_SEED, 14'h0001, LFSR start value; a value of 0 is replaced by 1.
MISR_SEED, 16'h0000, MISR start value.
GOLDEN, 16'h0000, expected final signature.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
start  in  1  one-cycle request to begin a run; ignored unless in IDLE or DONE.
dut_resp  in  OUT_W  netlist outputs, combinational function of tpg_out.
tpg_out  out  IN_W  registered stimulus to the netlist inputs.
busy  out  1  high in RUN and FLUSH.
done  out  1  high in DONE; held until the next accepted start.
pass  out  1  valid while done=1: signature==GOLDEN.
signature  out  SIG_W  current MISR contents.
pat_cnt  out  16  number of patterns issued in the current run.

Behaviour:
- Reset (async, rst=1): state=IDLE, tpg_out=LFSR_SEED (0 replaced by 1), signature=MISR_SEED, pat_cnt=0, busy=0, done=0, pass=0, resp_q=0, vld_q=0.
- Reset asserted mid-run aborts the run immediately; no partial done.
- LFSR step (Fibonacci): fb = l[13]^l[4]^l[2]^l[0]; l <= {l[12:0], fb}. Polynomial x^14+x^5+x^3+x+1, maximal, period 16383.
- MISR step: fb = m[15]^m[14]^m[12]^m[3]; m <= {m[14:0], fb} ^ zero-extended resp_q.
- Response pipeline: every cycle resp_q <= dut_resp and vld_q <= (state==RUN). The MISR steps only when vld_q=1.
- Latency: pattern k is on tpg_out during RUN cycle k. Its response is absorbed at the end of cycle k+1.
- IDLE/DONE + start: reload the LFSR and MISR seeds, set pat_cnt=0, clear done and pass, go to RUN. tpg_out shows the seed in the first RUN cycle.
- RUN: each cycle pat_cnt++. If pat_cnt==PATTERNS-1 (last pattern), go to FLUSH; otherwise the LFSR steps.
- FLUSH (1 cycle): the last response is absorbed; tpg_out is held. Next state is DONE.
- DONE: done=1 and pass=(signature==GOLDEN), both registered on entry. The signature is frozen.
- start while busy: ignored, no restart.
- start and rst together: rst wins.
- PATTERNS=1: RUN lasts one cycle, then FLUSH, then DONE.

Test Plan:
- Reset then start, PATTERNS=4, seed 1 -> tpg_out sequence 14'h0001, 14'h0003, 14'h0007, 14'h000E on consecutive cycles; busy high for 5 cycles; pat_cnt ends at 4.
- dut_resp tied to 0, MISR_SEED=0, GOLDEN=0 -> signature stays 16'h0000; done=1 and pass=1 exactly 2 cycles after the last pattern cycle.
- PATTERNS=1, dut_resp=10'h3FF, MISR_SEED=0, GOLDEN=16'h03FF -> signature=16'h03FF, pass=1. Same run with GOLDEN=16'h03FE -> pass=0.
- Connect a gate model instance, run PATTERNS=256 twice -> identical signatures. Then force one netlist output stuck-at-0 and rerun -> signature differs and pass=0.
- Pulse start during RUN -> ignored (pat_cnt continues, no reseed). Pulse start in DONE -> done clears next cycle and a new run begins from the seed.
- Assert rst at pattern 100 of 256 -> all outputs go to reset values immediately; a following start completes a normal run with the same signature as an uninterrupted run.

Source files
------------

// File: rtl/gate_model_bist.sv
// BIST controller for combinational gate netlists: an LFSR drives the
// stimulus, a MISR compacts the responses against a golden signature.
module gate_model_bist #(
    parameter int              IN_W      = 14,
    parameter int              OUT_W     = 10,
    parameter int              SIG_W     = 16,
    parameter int              PATTERNS  = 256,
    parameter logic [IN_W-1:0] LFSR_SEED = 14'h0001,
    parameter logic [SIG_W-1:0] MISR_SEED = 16'h0000,
    parameter logic [SIG_W-1:0] GOLDEN    = 16'h0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [OUT_W-1:0] dut_resp,
    output logic [IN_W-1:0]  tpg_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [SIG_W-1:0] signature,
    output logic [15:0]      pat_cnt
);

    localparam logic [IN_W-1:0] SEED_L =
        (LFSR_SEED == '0) ? IN_W'(1) : LFSR_SEED;
    localparam logic [15:0] LAST = 16'(PATTERNS - 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t           state, state_n;
    logic [IN_W-1:0]  lfsr, lfsr_nxt;
    logic [SIG_W-1:0] misr, misr_nxt, misr_eff;
    logic [OUT_W-1:0] resp_q;
    logic             vld_q;
    logic             pass_q;
    logic             accept;

    always_comb begin
        state_n  = state;
        accept   = 1'b0;
        lfsr_nxt = {lfsr[IN_W-2:0], lfsr[13] ^ lfsr[4] ^ lfsr[2] ^ lfsr[0]};
        misr_nxt = {misr[SIG_W-2:0], misr[15] ^ misr[14] ^ misr[12] ^ misr[3]}
                   ^ SIG_W'(resp_q);
        misr_eff = vld_q ? misr_nxt : misr;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_n = RUN;
                end
            end
            RUN:     if (pat_cnt == LAST) state_n = FLUSH;
            FLUSH:   state_n = DONE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            lfsr    <= SEED_L;
            misr    <= MISR_SEED;
            pat_cnt <= '0;
            pass_q  <= 1'b0;
            resp_q  <= '0;
            vld_q   <= 1'b0;
        end else begin
            state  <= state_n;
            resp_q <= dut_resp;
            vld_q  <= (state == RUN);
            if (accept) begin
                lfsr    <= SEED_L;
                misr    <= MISR_SEED;
                pat_cnt <= '0;
                pass_q  <= 1'b0;
            end else begin
                if (state == RUN) begin
                    pat_cnt <= pat_cnt + 16'd1;
                    if (pat_cnt != LAST) lfsr <= lfsr_nxt;
                end
                if (vld_q) misr <= misr_nxt;
                // the last response lands in FLUSH, so judge the post-absorb value
                if (state == FLUSH) pass_q <= (misr_eff == GOLDEN);
            end
        end
    end

    assign tpg_out   = lfsr;
    assign signature = misr;
    assign busy      = (state == RUN) || (state == FLUSH);
    assign done      = (state == DONE);
    assign pass      = pass_q;

endmodule
